// File: rtl/eq_pkg.sv
// Shared constants, FSM state type and the audio saturation helper for the
// equalizer band scheduler.
package eq_pkg;

  localparam int AUD_W     = 16;
  localparam int POT_W     = 12;
  localparam int NUM_BANDS = 5;
  localparam int ACC_W     = AUD_W + 3;

  localparam logic [AUD_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [AUD_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Clip an accumulator-width value into the signed audio range.
  function automatic logic signed [AUD_W-1:0] sat_aud(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-AUD_W:0] hi;
    hi = v[ACC_W-1:AUD_W-1];
    if ((&hi) || !(|hi)) return v[AUD_W-1:0];
    else if (v[ACC_W-1]) return SAT_MIN;
    else return SAT_MAX;
  endfunction

endpackage

// File: rtl/eq_gain_pipe.sv
// Two-stage pot-squared gain scaler: stage 1 squares the pot, stage 2 applies
// the gain to the sample; the result is taken from the stage-2 register.
module eq_gain_pipe
  import eq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld_i,
  input  logic signed [AUD_W-1:0] aud_i,
  input  logic        [POT_W-1:0] pot_i,
  output logic                    s1_vld_o,
  output logic                    res_vld_o,
  output logic signed [AUD_W-1:0] res_o
);

  localparam int PROD_W = AUD_W + POT_W + 1;

  logic        [2*POT_W-1:0] sq;
  logic        [POT_W-1:0]   gain_q;
  logic signed [AUD_W-1:0]   aud1_q;
  logic signed [PROD_W-1:0]  prod_d, prod_q;
  logic                      vld1_q, vld2_q;
  logic        [PROD_W-AUD_W-10:0] prod_hi;

  assign sq     = (2*POT_W)'(pot_i) * (2*POT_W)'(pot_i);
  assign prod_d = PROD_W'($signed({1'b0, gain_q})) * PROD_W'(aud1_q);

  // Data path carries no reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    gain_q <= sq[2*POT_W-1:POT_W];
    aud1_q <= aud_i;
    prod_q <= prod_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
    end else begin
      vld1_q <= in_vld_i;
      vld2_q <= vld1_q;
    end
  end

  assign prod_hi = prod_q[PROD_W-1:AUD_W+9];

  always_comb begin
    res_o = prod_q[AUD_W+9:10];
    if (!((&prod_hi) || !(|prod_hi))) res_o = prod_q[PROD_W-1] ? SAT_MIN : SAT_MAX;
  end

  assign s1_vld_o  = vld1_q;
  assign res_vld_o = vld2_q;

endmodule

// File: rtl/eq_band_sched.sv
// Captures all band samples/pots on vld, streams one band per cycle through the
// shared gain scaler and emits the saturated mix of the scaled results.
module eq_band_sched
  import eq_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           vld,
  input  logic [NUM_BANDS*AUD_W-1:0]     band_aud,
  input  logic [NUM_BANDS*POT_W-1:0]     band_pot,
  output logic signed [AUD_W-1:0]        aud_out,
  output logic                           out_vld,
  output logic                           busy,
  output logic                           overrun,
  output state_t                         state_dbg
);

  localparam int                IDX_W    = $clog2(NUM_BANDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BANDS - 1);

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NUM_BANDS*AUD_W-1:0]   aud_h_q, aud_h_d;
  logic [NUM_BANDS*POT_W-1:0]   pot_h_q, pot_h_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [AUD_W-1:0]      aud_out_q, aud_out_d;
  logic                         out_vld_q, out_vld_d;
  logic                         overrun_q, overrun_d;

  logic                         issue_vld;
  logic signed [AUD_W-1:0]      issue_aud;
  logic        [POT_W-1:0]      issue_pot;
  logic                         s1_vld, res_vld, last_res;
  logic signed [AUD_W-1:0]      res;
  logic signed [ACC_W-1:0]      sum;

  assign issue_vld = (state_q == ISSUE);
  assign issue_aud = aud_h_q[idx_q*AUD_W +: AUD_W];
  assign issue_pot = pot_h_q[idx_q*POT_W +: POT_W];

  eq_gain_pipe u_gain (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld_i  (issue_vld),
    .aud_i     (issue_aud),
    .pot_i     (issue_pot),
    .s1_vld_o  (s1_vld),
    .res_vld_o (res_vld),
    .res_o     (res)
  );

  assign sum = acc_q + ACC_W'(res);
  // Once issuing stops, the final result is the one leaving stage 2 with stage 1 empty.
  assign last_res = (state_q == DRAIN) && res_vld && !s1_vld;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    aud_h_d   = aud_h_q;
    pot_h_d   = pot_h_q;
    acc_d     = acc_q;
    aud_out_d = aud_out_q;
    out_vld_d = 1'b0;
    overrun_d = overrun_q;

    if (vld && state_q != IDLE) overrun_d = 1'b1;
    if (res_vld) acc_d = sum;
    if (last_res) begin
      aud_out_d = sat_aud(sum);
      out_vld_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (vld) begin
          aud_h_d = band_aud;
          pot_h_d = band_pot;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_vld) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      aud_h_q   <= '0;
      pot_h_q   <= '0;
      acc_q     <= '0;
      aud_out_q <= '0;
      out_vld_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      aud_h_q   <= aud_h_d;
      pot_h_q   <= pot_h_d;
      acc_q     <= acc_d;
      aud_out_q <= aud_out_d;
      out_vld_q <= out_vld_d;
      overrun_q <= overrun_d;
    end
  end

  assign aud_out   = aud_out_q;
  assign out_vld   = out_vld_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_eq_band_sched.sv
// Bench for eq_band_sched: per-cycle stimulus is recorded, and a frame-level
// model (arithmetic mix + frame window timing) predicts every output each cycle.
module tb_eq_band_sched;
  import eq_pkg::*;

  localparam int NB   = NUM_BANDS;
  localparam int MAXC = 4096;
  localparam int AW   = NB * AUD_W;
  localparam int PW   = NB * POT_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            vld;
  logic [AW-1:0]   band_aud;
  logic [PW-1:0]   band_pot;
  logic [AUD_W-1:0] aud_out;
  logic            out_vld;
  logic            busy;
  logic            overrun;
  state_t          state_dbg;

  eq_band_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (vld),
    .band_aud  (band_aud),
    .band_pot  (band_pot),
    .aud_out   (aud_out),
    .out_vld   (out_vld),
    .busy      (busy),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic          rec_vld [MAXC];
  logic          rec_rst [MAXC];
  logic [AW-1:0] rec_aud [MAXC];
  logic [PW-1:0] rec_pot [MAXC];

  logic [AW-1:0] cur_aud;
  logic [PW-1:0] cur_pot;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint clip16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int mix_model(input logic [AW-1:0] a, input logic [PW-1:0] p);
    longint total = 0;
    for (int b = 0; b < NB; b++) begin
      logic signed [AUD_W-1:0] s;
      longint pot, gain, prod;
      s    = a[b*AUD_W +: AUD_W];
      pot  = longint'(p[b*POT_W +: POT_W]);
      gain = (pot * pot) / 4096;
      prod = gain * longint'(s);
      total += clip16(prod >>> 10);
    end
    return int'(clip16(total));
  endfunction

  // ---------------- scoreboard ----------------
  logic [AUD_W-1:0] exp_q[$];
  int               fr_start = -1;
  logic [AUD_W-1:0] exp_aud = '0;
  logic             exp_ovr = 1'b0;
  logic             exp_ov  = 1'b0;
  logic             exp_busy;
  logic             busy_p;
  int               p;

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      p = cyc - 1;
      if (!rec_rst[p]) begin
        fr_start = -1;
        exp_q.delete();
        exp_aud = '0;
        exp_ovr = 1'b0;
        exp_ov  = 1'b0;
      end else begin
        busy_p = (fr_start >= 0) && (p >= fr_start + 1) && (p <= fr_start + NB + 2);
        exp_ov = 1'b0;
        if (fr_start >= 0 && cyc == fr_start + NB + 3) begin
          exp_ov   = 1'b1;
          exp_aud  = exp_q.pop_front();
          fr_start = -1;
        end
        if (rec_vld[p]) begin
          if (busy_p) exp_ovr = 1'b1;
          else begin
            fr_start = p;
            exp_q.push_back(16'(mix_model(rec_aud[p], rec_pot[p])));
          end
        end
      end
      exp_busy = (fr_start >= 0) && (cyc >= fr_start + 1) && (cyc <= fr_start + NB + 2);
      check("out_vld", 32'(out_vld), 32'(exp_ov));
      check("aud_out", 32'(aud_out), 32'(exp_aud));
      check("busy", 32'(busy), 32'(exp_busy));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      check("state_idle", 32'(state_dbg == IDLE), 32'(!exp_busy));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic r);
    @(posedge clk);
    #1;
    vld      = v;
    rst_n    = r;
    band_aud = cur_aud;
    band_pot = cur_pot;
    if (cyc < MAXC) begin
      rec_vld[cyc] = v;
      rec_rst[cyc] = r;
      rec_aud[cyc] = cur_aud;
      rec_pot[cyc] = cur_pot;
    end
  endtask

  task automatic randomize_inputs();
    for (int b = 0; b < NB; b++) begin
      cur_aud[b*AUD_W +: AUD_W] = AUD_W'($urandom);
      cur_pot[b*POT_W +: POT_W] = POT_W'($urandom);
    end
  endtask

  // Idle (with scrambled inputs) until the next step() drives cycle c.
  task automatic idle_until(input int c);
    while (cyc < c - 1) begin
      randomize_inputs();
      step(1'b0, 1'b1);
    end
  endtask

  task automatic frame(input logic [AW-1:0] a, input logic [PW-1:0] pt, output int t0);
    cur_aud = a;
    cur_pot = pt;
    step(1'b1, 1'b1);
    t0 = cyc;
  endtask

  task automatic at_cycle(input int c);
    idle_until(c);
    randomize_inputs();
    step(1'b0, 1'b1);
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [AW-1:0] a_v;
    logic [PW-1:0] p_v;
    int t0, t1;
    bit v;

    for (int i = 0; i < MAXC; i++) begin
      rec_vld[i] = 1'b0;
      rec_rst[i] = 1'b0;
      rec_aud[i] = '0;
      rec_pot[i] = '0;
    end
    rst_n = 1'b0; vld = 1'b0; band_aud = '0; band_pot = '0;
    cur_aud = '0; cur_pot = '0;

    // Hand-computed pins of the model.
    check("model_unity", mix_model({NB{16'd1000}}, {NB{12'h800}}), 5000);
    p_v = '0; p_v[2*POT_W +: POT_W] = 12'hFFF;
    a_v = {NB{16'h1234}}; a_v[2*AUD_W +: AUD_W] = 16'h1000;
    check("model_single", mix_model(a_v, p_v), 16376);
    check("model_satpos", mix_model({NB{16'h7FFF}}, {NB{12'hFFF}}), 32767);
    check("model_satneg", mix_model({NB{16'h8000}}, {NB{12'h800}}), -32768);

    repeat (3) step(1'b0, 1'b0);
    @(negedge clk);
    check("rst_aud_out", 32'(aud_out), 0);
    check("rst_busy", 32'(busy), 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Unity mix; inputs scrambled after capture.
    frame({NB{16'd1000}}, {NB{12'h800}}, t0);
    at_cycle(t0 + 1);
    check("unity_busy_first", 32'(busy), 1);
    at_cycle(t0 + NB + 2);
    check("unity_busy_last", 32'(busy), 1);
    check("unity_no_early_vld", 32'(out_vld), 0);
    at_cycle(t0 + NB + 3);
    check("unity_vld", 32'(out_vld), 1);
    check("unity_aud", 32'(aud_out), 5000);
    check("unity_busy_done", 32'(busy), 0);
    at_cycle(t0 + NB + 5);
    check("unity_hold", 32'(aud_out), 5000);

    // Single band at max gain.
    frame(a_v, p_v, t0);
    at_cycle(t0 + NB + 3);
    check("single_aud", 32'(aud_out), 32'h3FF8);

    frame({NB{16'h7FFF}}, {NB{12'hFFF}}, t0);
    at_cycle(t0 + NB + 3);
    check("sat_pos", 32'(aud_out), 32'h7FFF);

    frame({NB{16'h8000}}, {NB{12'h800}}, t0);
    at_cycle(t0 + NB + 3);
    check("sat_neg", 32'(aud_out), 32'h8000);

    // Overrun: second strobe mid-frame ignored, strobe in out_vld cycle accepted.
    frame({NB{16'd1000}}, {NB{12'h800}}, t0);
    idle_until(t0 + 4);
    cur_aud = {NB{16'd2000}};
    step(1'b1, 1'b1);
    at_cycle(t0 + 5);
    check("ovr_set", 32'(overrun), 1);
    idle_until(t0 + NB + 3);
    cur_aud = {NB{16'd300}};
    cur_pot = {NB{12'h800}};
    step(1'b1, 1'b1);
    t1 = cyc;
    @(negedge clk);
    check("ovr_first_vld", 32'(out_vld), 1);
    check("ovr_first_aud", 32'(aud_out), 5000);
    at_cycle(t1 + NB + 3);
    check("ovr_second_aud", 32'(aud_out), 1500);
    check("ovr_sticky", 32'(overrun), 1);

    // Reset mid-frame.
    frame({NB{16'd1000}}, {NB{12'h800}}, t0);
    idle_until(t0 + 4);
    step(1'b0, 1'b0);
    at_cycle(t0 + 5);
    check("mid_rst_aud", 32'(aud_out), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ovr", 32'(overrun), 0);
    cur_aud = {NB{16'd123}};
    cur_pot = {NB{12'h800}};
    step(1'b1, 1'b1);
    t1 = cyc;
    at_cycle(t1 + NB + 3);
    check("post_rst_aud", 32'(aud_out), 615);

    // Back-to-back frames at minimum spacing.
    for (int f = 0; f < 30; f++) begin
      randomize_inputs();
      step(1'b1, 1'b1);
      for (int k = 0; k < NB + 2; k++) begin
        randomize_inputs();
        step(1'b0, 1'b1);
      end
    end
    @(negedge clk);
    check("b2b_no_ovr", 32'(overrun), 0);

    // Random strobes, including overruns and occasional resets.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      if ($urandom_range(0, 4) == 0) cur_pot = {NB{12'hFFF}};
      v = ($urandom_range(0, 3) == 0);
      step(v, ($urandom_range(0, 80) != 0));
    end

    repeat (NB + 6) step(1'b0, 1'b1);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
